// File: rtl/sram_pkg.sv
// Shared widths and FSM encoding for the external SRAM arbiter.
package sram_pkg;

    localparam int SRAM_AW = 21;
    localparam int SRAM_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant; bit 0 is port A, bit 1 is port B.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_b;

    // Single requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prefer_b ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After each grant, priority passes to the port that was not served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_b <= 1'b0;
        end else if (advance) begin
            prefer_b <= grant[0];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 8-bit SRAM between two synchronous requesters.
// Writes run setup / strobe / hold; reads wait RD_CYCLES then capture.
// Read data is passed straight from the pins during the ack cycle and
// held in a register afterwards, so it is valid in the ack cycle itself.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int RD_CYCLES = 1,
    parameter int WE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [SRAM_AW-1:0]   a_addr,
    input  logic [SRAM_DW-1:0]   a_wdata,
    output logic [SRAM_DW-1:0]   a_rdata,
    output logic                 a_ack,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [SRAM_AW-1:0]   b_addr,
    input  logic [SRAM_DW-1:0]   b_wdata,
    output logic [SRAM_DW-1:0]   b_rdata,
    output logic                 b_ack,

    output logic [SRAM_AW-1:0]   sram_a,
    inout  wire  [SRAM_DW-1:0]   sram_d,
    output logic                 sram_we_n
);

    localparam logic [15:0] RD_LAST = 16'(RD_CYCLES);
    localparam logic [15:0] WE_LAST = 16'(WE_CYCLES);

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 sel_b_q, sel_b_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [SRAM_DW-1:0]   wdata_q, wdata_d;
    logic                 we_n_q, we_n_d;
    logic                 drive_q, drive_d;
    logic                 a_ack_q, b_ack_q;
    logic                 ack_d;
    logic [SRAM_DW-1:0]   a_rdata_q, b_rdata_q;
    logic                 capture;
    logic                 advance;
    logic [1:0]           grant;

    sram_rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_req, a_req}),
        .advance (advance),
        .grant   (grant)
    );

    // Next-state and next registered-output values; outputs decode the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_b_d = sel_b_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        advance = 1'b0;
        capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    advance = 1'b1;
                    sel_b_d = grant[1];
                    addr_d  = grant[1] ? b_addr  : a_addr;
                    wdata_d = grant[1] ? b_wdata : a_wdata;
                    cnt_d   = 16'd1;
                    state_d = (grant[1] ? b_we : a_we) ? ST_WR_SETUP : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WR_SETUP: begin
                cnt_d   = 16'd1;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d   = (state_d == ST_WR_HOLD) ||
                  ((state_d == ST_RD_WAIT) && (cnt_d == RD_LAST));
        we_n_d  = (state_d != ST_WR_PULSE);
        drive_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                  (state_d == ST_WR_HOLD);
    end

    // State, latched transaction and every pin-facing output are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            sel_b_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_n_q    <= 1'b1;
            drive_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_b_q <= sel_b_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
            a_ack_q <= ack_d && !sel_b_d;
            b_ack_q <= ack_d && sel_b_d;
            if (capture && !sel_b_q) begin
                a_rdata_q <= sram_d;
            end
            if (capture && sel_b_q) begin
                b_rdata_q <= sram_d;
            end
        end
    end

    assign sram_a    = addr_q;
    assign sram_we_n = we_n_q;
    assign sram_d    = drive_q ? wdata_q : {SRAM_DW{1'bz}};
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = (a_ack_q && (state_q == ST_RD_WAIT)) ? sram_d : a_rdata_q;
    assign b_rdata   = (b_ack_q && (state_q == ST_RD_WAIT)) ? sram_d : b_rdata_q;

endmodule
